// File: rtl/fir_pkg.sv
// fir_pkg: shared sample type, stimulus FSM states and saturating add for the fir stimulus generator.
package fir_pkg;
    localparam int DATA_W = 20;
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef enum logic {IDLE, RUN} stim_state_t;
    function automatic sample_t sat_add(sample_t a, int d);
        int s;
        s = int'(a) + d;
        return (s > 2**(DATA_W-1) - 1) ? sample_t'(2**(DATA_W-1) - 1) :
               (s < -(2**(DATA_W-1))) ? sample_t'(-(2**(DATA_W-1))) : sample_t'(s);
    endfunction
endpackage

// File: rtl/fir_stim_gen_strobe_div.sv
// strobe_div: free-running 0..DIV-1 counter with sync clear; tick marks the wrap cycle.
module strobe_div #(
    parameter int DIV = 25
) (
    input  logic ck,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] r_cnt;
    logic          w_wrap;
    assign w_wrap = r_cnt == CW'(DIV - 1);
    assign tick   = !clr && w_wrap;
    always_ff @(posedge ck or negedge rst_n)
        if (!rst_n)
            r_cnt <= '0;
        else
            r_cnt <= (clr || w_wrap) ? '0 : r_cnt + CW'(1);
endmodule

// File: rtl/fir_stim_gen.sv
// fir_stim_gen: square-wave sample source with a one-cycle input_ready strobe every SAMPLE_DIV clocks.
// Define FIR_STIM_DITHER_EN to add saturating LFSR dither (-2..+1) to every sample.
module fir_stim_gen
    import fir_pkg::*;
#(
    parameter int SAMPLE_DIV = 25,
    parameter int HP_W       = 16
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [HP_W-1:0]   half_period,
    input  logic [DATA_W-2:0] amplitude,
    output sample_t           in,
    output logic              input_ready,
    output logic              busy
);
    stim_state_t       r_state;
    logic [HP_W-1:0]   r_hp;
    logic [HP_W-1:0]   r_samp_cnt;
    logic [DATA_W-2:0] r_amp;
    logic              r_neg;
    logic              w_tick;
    logic              w_last;
    sample_t           w_mag;
    sample_t           w_sq;
`ifdef FIR_STIM_DITHER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] r_lfsr;
`endif

    strobe_div #(.DIV(SAMPLE_DIV)) u_div (
        .ck   (ck),
        .rst_n(rst_n),
        .clr  (!(r_state == RUN && enable)),
        .tick (w_tick)
    );

    // half_period of 0 behaves as 1, so every sample is the last of its half
    assign w_last = (r_hp == '0) || (r_samp_cnt == r_hp - HP_W'(1));
    assign w_mag  = sample_t'({1'b0, r_amp});
    assign w_sq   = r_neg ? -w_mag : w_mag;

    always_ff @(posedge ck or negedge rst_n)
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hp        <= '0;
            r_samp_cnt  <= '0;
            r_amp       <= '0;
            r_neg       <= 1'b0;
            in          <= '0;
            input_ready <= 1'b0;
            busy        <= 1'b0;
`ifdef FIR_STIM_DITHER_EN
            r_lfsr      <= LFSR_SEED;
`endif
        end else if (r_state == IDLE || !enable) begin
            r_state     <= (r_state == IDLE && enable) ? RUN : IDLE;
            busy        <= r_state == IDLE && enable;
            in          <= '0;
            input_ready <= 1'b0;
            r_samp_cnt  <= '0;
            r_neg       <= 1'b0;
            if (r_state == IDLE) begin
                r_hp  <= half_period;
                r_amp <= amplitude;
            end
`ifdef FIR_STIM_DITHER_EN
            if (r_state == IDLE)
                r_lfsr <= LFSR_SEED;
`endif
        end else begin
            input_ready <= w_tick;
            if (w_tick) begin
`ifdef FIR_STIM_DITHER_EN
                in     <= sat_add(w_sq, int'({30'd0, r_lfsr[1:0]}) - 2);
                r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
`else
                in     <= w_sq;
`endif
                r_samp_cnt <= w_last ? '0 : r_samp_cnt + HP_W'(1);
                if (w_last) begin
                    r_neg <= !r_neg;
                    r_hp  <= half_period;
                    r_amp <= amplitude;
                end
            end
        end
endmodule

// File: tb/tb_fir_stim_gen.sv
// tb_fir_stim_gen: directed and randomized stimulus checked every cycle against a sample-level reference model.
module tb_fir_stim_gen;
    import fir_pkg::*;
    localparam int DIV = 25;

    logic              ck = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [15:0]       half_period = '0;
    logic [DATA_W-2:0] amplitude = '0;
    sample_t           in;
    logic              input_ready;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_run, m_neg, m_rdy;
    int m_cyc, m_pos, m_hp, m_amp, m_in, m_lfsr;

    always #5 ck = ~ck;

    fir_stim_gen #(.SAMPLE_DIV(DIV), .HP_W(16)) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .enable     (enable),
        .half_period(half_period),
        .amplitude  (amplitude),
        .in         (in),
        .input_ready(input_ready),
        .busy       (busy)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_rdy  = 1'b0;
        m_in   = 0;
        m_lfsr = 'hACE1;
    endtask

    // One clock edge of the reference: samples come every DIV cycles of a run,
    // and amp/hp are re-read only at a run start or after the hp-th sample of a half.
    task automatic model_edge();
        int v;
        if (!m_run) begin
            m_rdy  = 1'b0;
            m_in   = 0;
            m_lfsr = 'hACE1;
            if (enable) begin
                m_run = 1'b1;
                m_cyc = 0;
                m_pos = 0;
                m_neg = 1'b0;
                m_amp = int'(amplitude);
                m_hp  = (half_period == 0) ? 1 : int'(half_period);
            end
        end else if (!enable) begin
            m_run = 1'b0;
            m_rdy = 1'b0;
            m_in  = 0;
        end else begin
            m_cyc++;
            m_rdy = (m_cyc % DIV) == 0;
            if (m_rdy) begin
                v = m_neg ? -m_amp : m_amp;
`ifdef FIR_STIM_DITHER_EN
                v = v + (m_lfsr % 4) - 2;
                if (v > 2**(DATA_W-1) - 1) v = 2**(DATA_W-1) - 1;
                if (v < -(2**(DATA_W-1))) v = -(2**(DATA_W-1));
                m_lfsr = (m_lfsr / 2) + 32768 * ((m_lfsr ^ (m_lfsr / 4) ^ (m_lfsr / 8) ^ (m_lfsr / 32)) % 2);
`endif
                m_in = v;
                m_pos++;
                if (m_pos == m_hp) begin
                    m_pos = 0;
                    m_neg = !m_neg;
                    m_amp = int'(amplitude);
                    m_hp  = (half_period == 0) ? 1 : int'(half_period);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge ck);
        model_edge();
        #1;
        chk("in", in, m_in);
        chk("input_ready", input_ready, m_rdy);
        chk("busy", busy, m_run);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_in", in, 0);
        chk("async_rst_ready", input_ready, 0);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge ck);
        chk("held_rst_in", in, 0);
        chk("held_rst_busy", busy, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rv;
        int r;
        model_reset();
        repeat (3) @(negedge ck);
        chk("rst_in", in, 0);
        chk("rst_ready", input_ready, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        run(3);
        half_period = 16'd4;
        amplitude   = 19'd10000;
        enable      = 1'b1;
        run(DIV * 6);
        amplitude = 19'd500;
        run(DIV * 10);
        half_period = 16'd0;
        amplitude   = 19'd1;
        run(DIV * 12);
        half_period = 16'd2;
        amplitude   = 19'h7FFFF;
        run(DIV * 10);
        run(7);
        enable = 1'b0;
        run(4);
        half_period = 16'd3;
        amplitude   = 19'd777;
        enable      = 1'b1;
        run(DIV * 8);
        run(30);
        do_reset();
        run(DIV * 4);
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 5) begin
                enable = ~enable;
            end else if (r < 20) begin
                rv = $urandom;
                amplitude = rv[DATA_W-2:0];
            end else if (r < 23) begin
                amplitude = '1;
            end else if (r < 33) begin
                rv = $urandom_range(0, 5);
                half_period = rv[15:0];
            end else if (r < 35) begin
                do_reset();
            end
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
